apb_uart_master: RTL and testbench
==================================

APB_UART_MASTER -- requirements
Module: apb_uart_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max ACCESS-phase wait cycles before abort; 0 disables timeout.
REQ-002 Parameter ADDR_W, default 12, PADDR/cmd_addr width.
REQ-003 PCLK  input  1  sole clock; all logic on rising edge.
REQ-004 PRESET  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  ADDR_W  target register address.
REQ-009 cmd_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and aborts.
REQ-013 rsp_error  output  1  1 = transfer aborted by timeout.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-016 PADDR  output  ADDR_W; PWDATA  output  8.
REQ-017 PREADY  input  1; PRDATA  input  32  APB responder return.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, RESP; one state register.
REQ-019 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE is ignored, not queued.
REQ-020 Accept in IDLE: latch cmd_write/addr/wdata, next state SETUP.
REQ-021 SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from latched values; next ACCESS.
REQ-022 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable; remains until PREADY sampled 1.
REQ-023 PREADY=1 in ACCESS: capture PRDATA into rsp_rdata if read (0 if write), rsp_error=0, next RESP.
REQ-024 PREADY outside ACCESS SHALL be ignored.
REQ-025 Timeout: 8-bit-min wait counter cleared entering ACCESS, increments each ACCESS cycle with PREADY=0; reaching TIMEOUT_CYCLES -> RESP with rsp_error=1, rsp_rdata=0.
REQ-026 PREADY=1 on the same cycle the counter reaches TIMEOUT_CYCLES: normal completion wins, rsp_error=0.
REQ-027 RESP: rsp_valid=1, PSEL=PENABLE=0; held with stable rsp_rdata/rsp_error until rsp_ready=1, then IDLE.
REQ-028 Minimum transaction latency: accept edge to rsp_valid = 3 cycles with zero-wait PREADY; back-to-back issue period = 4 cycles.
REQ-029 In IDLE and RESP: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
REQ-030 Outputs registered; no combinational path from PREADY/PRDATA to any output.

Reset
REQ-031 PRESET=1 at a PCLK edge SHALL force IDLE from any state, including mid-ACCESS, aborting without response.
REQ-032 Reset values: cmd_ready=1 (after reset deasserts), rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, all APB outputs 0, wait counter 0.

Structure
REQ-033 Shared package apb_uart_pkg holds FSM state enum and UART register address constants: DATA=12'h400, STATE=12'h404, CTRL=12'h408, BAUD=12'h410.
REQ-034 Single module, no sub-modules; timeout counter inline.

Verification
REQ-035 Write 0xD8 to 12'h400, PREADY low 3 ACCESS cycles -> ACCESS lasts 4 cycles, PADDR/PWDATA stable, rsp_valid rdata=0 error=0.
REQ-036 Read 12'h410, PREADY=1 first ACCESS cycle, PRDATA=32'h0007_0800 -> rsp_rdata=32'h0007_0800 exactly 3 cycles after accept.
REQ-037 TIMEOUT_CYCLES=8, PREADY held 0 -> abort after 8 ACCESS cycles, rsp_error=1, rsp_rdata=0, PSEL drops.
REQ-038 rsp_ready low 5 cycles in RESP with second cmd_valid asserted -> response held stable, second command not accepted until IDLE.
REQ-039 PRESET pulsed during ACCESS -> next cycle PSEL=PENABLE=0, rsp_valid=0, cmd_ready=1 after release.
REQ-040 PREADY and timeout coincide (TIMEOUT_CYCLES=4, PREADY on 4th wait) -> rsp_error=0, PRDATA captured.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: shared FSM state type and UART register map for the APB UART master
package apb_uart_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam logic [11:0] UART_DATA  = 12'h400;
  localparam logic [11:0] UART_STATE = 12'h404;
  localparam logic [11:0] UART_CTRL  = 12'h408;
  localparam logic [11:0] UART_BAUD  = 12'h410;
endpackage

// File: rtl/apb_uart_master.sv
// apb_uart_master: single-command APB master with ACCESS-phase timeout and held response
module apb_uart_master
  import apb_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 12
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [7:0]        PWDATA,
  input  logic              PREADY,
  input  logic [31:0]       PRDATA
);
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] wdata_q;
  logic wr_q, done, tmo;
  always_comb begin
    cnt_inc = cnt + 1'b1;
    done = state == ACCESS && PREADY;
    tmo = state == ACCESS && !PREADY && TIMEOUT_CYCLES != 0 && cnt_inc == CW'(TIMEOUT_CYCLES);
    state_nxt = state == IDLE   ? (cmd_valid ? SETUP : IDLE) :
                state == SETUP  ? ACCESS :
                state == ACCESS ? (done || tmo ? RESP : ACCESS) :
                                  (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        wr_q <= cmd_write;
        addr_q <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      cnt <= state == ACCESS ? (PREADY ? cnt : cnt_inc) : '0;
      if (done) begin
        rsp_rdata <= wr_q ? '0 : PRDATA;
        rsp_error <= 1'b0;
      end else if (tmo) begin
        rsp_rdata <= '0;
        rsp_error <= 1'b1;
      end
    end
  end
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign PSEL = state == SETUP || state == ACCESS;
  assign PENABLE = state == ACCESS;
  assign PWRITE = PSEL && wr_q;
  assign PADDR = PSEL ? addr_q : '0;
  assign PWDATA = PSEL ? wdata_q : '0;
endmodule

// File: tb/tb_apb_uart_master.sv
// tb_apb_uart_master: randomized transactions against an outcome-level model of the APB master
module tb_apb_uart_master;
  import apb_uart_pkg::*;
  localparam int TO = 8;
  logic PCLK = 0, PRESET = 1, cmd_valid = 0, cmd_write = 0, rsp_ready = 0, PREADY = 0;
  logic [11:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [31:0] PRDATA = '0;
  logic cmd_ready, rsp_valid, rsp_error, busy, PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata;
  logic [11:0] PADDR;
  logic [7:0] PWDATA;
  int vectors = 0, miscompares = 0;
  logic o_acc_rdy, o_setup, o_stable, o_hold, o_idle, o_valid, o_err;
  logic [31:0] o_rdata;
  int o_lat, o_acc;
  always #5 PCLK = ~PCLK;
  apb_uart_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(12)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );
  // Issues one command and records what the DUT did; waits = PREADY-low ACCESS cycles before PREADY.
  task automatic do_txn(input logic w, input logic [11:0] a, input logic [7:0] d,
                        input int waits, input logic [31:0] prd, input int hold);
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    PREADY = 1'($urandom); PRDATA = $urandom;
    o_acc_rdy = cmd_ready;
    @(negedge PCLK);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 12'($urandom); cmd_wdata = 8'($urandom);
    o_setup = PSEL && !PENABLE && PADDR == a && PWRITE == w && PWDATA == d && busy && !cmd_ready;
    PREADY = 1'($urandom);
    o_lat = 1; o_acc = 0; o_stable = 1;
    @(negedge PCLK); o_lat++;
    while (PSEL && PENABLE && o_acc < 40) begin
      o_acc++;
      o_stable &= PADDR == a && PWRITE == w && PWDATA == d && !rsp_valid;
      PREADY = o_acc > waits;
      PRDATA = PREADY ? prd : $urandom;
      @(negedge PCLK); o_lat++;
    end
    PREADY = 1'($urandom); PRDATA = $urandom;
    o_valid = rsp_valid; o_rdata = rsp_rdata; o_err = rsp_error; o_hold = 1;
    rsp_ready = hold == 0; cmd_valid = hold > 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge PCLK);
      o_hold &= rsp_valid && rsp_rdata == o_rdata && rsp_error == o_err && !cmd_ready && !PSEL && !PENABLE && busy;
      PREADY = 1'($urandom); PRDATA = $urandom;
      rsp_ready = i == hold - 1;
    end
    @(negedge PCLK);
    cmd_valid = 0; rsp_ready = 0;
    o_idle = !busy && cmd_ready && !rsp_valid && !PSEL && !PENABLE && !PWRITE && PADDR == 0 && PWDATA == 0;
  endtask
  task automatic test_reset();
    vectors++; if ({cmd_ready, rsp_valid, rsp_error, busy} !== 4'b1000) begin miscompares++; $display("FAIL reset_ctrl: got %b want 1000", {cmd_ready, rsp_valid, rsp_error, busy}); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    vectors++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 23'h0) begin miscompares++; $display("FAIL reset_apb: got %h want 0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}); end
  endtask
  task automatic test_write_wait();
    do_txn(1, UART_DATA, 8'hD8, 3, $urandom, 0);
    vectors++; if (o_acc !== 4) begin miscompares++; $display("FAIL write_access_len: got %0d want 4", o_acc); end
    vectors++; if ({o_acc_rdy, o_setup, o_stable, o_valid, o_idle} !== 5'b11111) begin miscompares++; $display("FAIL write_protocol: got %b want 11111", {o_acc_rdy, o_setup, o_stable, o_valid, o_idle}); end
    vectors++; if ({o_rdata, o_err} !== 33'h0) begin miscompares++; $display("FAIL write_rsp: got %h/%b want 0/0", o_rdata, o_err); end
  endtask
  task automatic test_read_zero_wait();
    do_txn(0, UART_BAUD, 8'h00, 0, 32'h0007_0800, 0);
    vectors++; if (o_lat !== 3) begin miscompares++; $display("FAIL read_latency: got %0d want 3", o_lat); end
    vectors++; if (o_rdata !== 32'h0007_0800 || o_err !== 0 || o_valid !== 1) begin miscompares++; $display("FAIL read_rsp: got %h/%b valid %b want 00070800/0 valid 1", o_rdata, o_err, o_valid); end
  endtask
  task automatic test_timeout();
    do_txn(0, UART_STATE, 8'h00, 20, 32'hDEAD_BEEF, 1);
    vectors++; if (o_acc !== TO) begin miscompares++; $display("FAIL timeout_len: got %0d want %0d", o_acc, TO); end
    vectors++; if (o_rdata !== 32'h0 || o_err !== 1 || o_valid !== 1) begin miscompares++; $display("FAIL timeout_rsp: got %h/%b valid %b want 0/1 valid 1", o_rdata, o_err, o_valid); end
    vectors++; if (o_idle !== 1) begin miscompares++; $display("FAIL timeout_idle: got %b want 1", o_idle); end
  endtask
  task automatic test_coincide();
    logic [31:0] prd = $urandom;
    do_txn(0, UART_DATA, 8'h00, TO - 1, prd, 0);
    vectors++; if (o_acc !== TO) begin miscompares++; $display("FAIL coincide_len: got %0d want %0d", o_acc, TO); end
    vectors++; if (o_rdata !== prd || o_err !== 0) begin miscompares++; $display("FAIL coincide_rsp: got %h/%b want %h/0", o_rdata, o_err, prd); end
  endtask
  task automatic test_rsp_hold();
    logic [31:0] prd = $urandom;
    do_txn(0, UART_CTRL, 8'h00, 2, prd, 5);
    vectors++; if (o_hold !== 1 || o_idle !== 1) begin miscompares++; $display("FAIL rsp_hold: got hold %b idle %b want 1 1", o_hold, o_idle); end
    vectors++; if (o_rdata !== prd) begin miscompares++; $display("FAIL rsp_hold_data: got %h want %h", o_rdata, prd); end
  endtask
  task automatic test_reset_mid_access();
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = UART_DATA; cmd_wdata = 8'h5A; PREADY = 0;
    @(negedge PCLK); cmd_valid = 0;
    repeat (2) @(negedge PCLK);
    vectors++; if (PENABLE !== 1) begin miscompares++; $display("FAIL mid_reset_setup: PENABLE got %b want 1", PENABLE); end
    PRESET = 1;
    @(negedge PCLK);
    vectors++; if ({PSEL, PENABLE, rsp_valid, busy} !== 4'b0000) begin miscompares++; $display("FAIL mid_reset: got %b want 0000", {PSEL, PENABLE, rsp_valid, busy}); end
    PRESET = 0;
    repeat (2) @(negedge PCLK);
    vectors++; if ({cmd_ready, rsp_valid, busy, PSEL} !== 4'b1000) begin miscompares++; $display("FAIL mid_reset_release: got %b want 1000", {cmd_ready, rsp_valid, busy, PSEL}); end
  endtask
  task automatic test_back_to_back();
    logic [11:0] rdy_pat, vld_pat;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = 0; rsp_ready = 1; PREADY = 1;
    for (int i = 0; i < 12; i++) begin
      rdy_pat[i] = cmd_ready; vld_pat[i] = rsp_valid;
      @(negedge PCLK);
    end
    cmd_valid = 0; rsp_ready = 0; PREADY = 0;
    vectors++; if (rdy_pat !== 12'h111) begin miscompares++; $display("FAIL b2b_ready: got %b want %b", rdy_pat, 12'h111); end
    vectors++; if (vld_pat !== 12'h888) begin miscompares++; $display("FAIL b2b_valid: got %b want %b", vld_pat, 12'h888); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic w = 1'($urandom);
      logic [11:0] a = 12'($urandom);
      logic [7:0] d = 8'($urandom);
      int waits = $urandom_range(0, 11);
      logic [31:0] prd = $urandom;
      int hold = $urandom_range(0, 3);
      logic e_err = waits >= TO;
      int e_acc = e_err ? TO : waits + 1;
      logic [31:0] e_rdata = (e_err || w) ? 32'h0 : prd;
      do_txn(w, a, d, waits, prd, hold);
      vectors++; if (o_acc !== e_acc || o_lat !== e_acc + 2) begin miscompares++; $display("FAIL rand%0d_timing: got acc %0d lat %0d want %0d %0d", n, o_acc, o_lat, e_acc, e_acc + 2); end
      vectors++; if (o_rdata !== e_rdata || o_err !== e_err) begin miscompares++; $display("FAIL rand%0d_rsp: got %h/%b want %h/%b", n, o_rdata, o_err, e_rdata, e_err); end
      vectors++; if ({o_acc_rdy, o_setup, o_stable, o_valid, o_hold, o_idle} !== 6'h3f) begin miscompares++; $display("FAIL rand%0d_protocol: got %b want 111111", n, {o_acc_rdy, o_setup, o_stable, o_valid, o_hold, o_idle}); end
    end
  endtask
  initial begin
    repeat (3) @(negedge PCLK);
    PRESET = 0;
    @(negedge PCLK);
    test_reset();
    test_write_wait();
    test_read_zero_wait();
    test_timeout();
    test_coincide();
    test_rsp_hold();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
